cu_write_command_arbiter_rr: RTL and testbench
==============================================

Name: cu_write_command_arbiter_rr

Overview:
- Round-robin arbiter that shares one CAPI write command buffer and its two write-data lanes among NUM_REQUESTERS write engines.
- Each engine presents a command plus two half-cacheline data lines.
- The arbiter grants one engine per cycle, registers the selected bundle toward the command/data buffers, and caps in-flight writes with a credit counter replenished by write responses.

Parameters:
- NUM_REQUESTERS, 4, number of write engines sharing the buffer (2..8).
- MAX_OUTSTANDING, 32, maximum granted writes awaiting response.
- CREDIT_BITS, $clog2(MAX_OUTSTANDING+1), credit counter width.

Ports:
- clock  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- enabled_in  input  1  block enable, registered internally
- command_in  input  CommandBufferLine[NUM_REQUESTERS]  per-engine write command; .valid = request
- write_data_0_in  input  ReadWriteDataLine[NUM_REQUESTERS]  per-engine data lane 0
- write_data_1_in  input  ReadWriteDataLine[NUM_REQUESTERS]  per-engine data lane 1
- ready_out  output  NUM_REQUESTERS  one-hot grant/pop strobe, combinational
- write_command_buffer_status  input  BufferStatus  downstream command buffer status
- write_response_in  input  ResponseBufferLine  write completion, one per granted command
- write_command_out  output  CommandBufferLine  registered granted command
- write_data_0_out  output  ReadWriteDataLine  registered granted lane 0
- write_data_1_out  output  ReadWriteDataLine  registered granted lane 1
- outstanding_out  output  CREDIT_BITS  writes granted minus responses received
- grant_count_out  output  32  total grants since reset

Behaviour:
- Reset values:
  - Outputs: all struct outputs 0, ready_out 0, outstanding_out 0, grant_count_out 0.
  - Internal: credits = MAX_OUTSTANDING, rr pointer = 0, enabled = 0.
- enabled <= enabled_in each cycle. While enabled = 0: no grants; output regs load 0; credit and response accounting continue.
- Eligibility: requester i is eligible when all of the following hold:
  - command_in[i].valid, write_data_0_in[i].valid and write_data_1_in[i].valid are all 1;
  - enabled = 1;
  - ~write_command_buffer_status.alfull;
  - credits > 0.
- Command valid without both data valids is not eligible; no partial grant.
- Arbitration (combinational, cycle t):
  - Search order is pointer, pointer+1, …, wrapping mod NUM_REQUESTERS; the first eligible requester wins.
  - ready_out = one-hot of the winner, or 0 if none.
- Handshake: the requester treats ready_out[i] as a pop and must present its next entry (or deassert valid) at t+1.
- Output register at t+1:
  - write_command_out, write_data_0_out, write_data_1_out take the winner's inputs unmodified, with .valid = 1.
  - With no grant at t, all three are 0 at t+1.
  - Fixed latency: 1 cycle.
- Pointer update: on a grant, pointer <= (winner+1) mod NUM_REQUESTERS. With no grant, the pointer holds.
- Fairness: with all requesters continuously eligible, the grant sequence is 0,1,…,N-1,0,…; each requester waits at most N-1 grants.
- Credits:
  - Grant only: credits - 1.
  - write_response_in.valid only: credits + 1.
  - Both in one cycle: unchanged.
  - Neither: unchanged.
  - outstanding_out = MAX_OUTSTANDING - credits, registered.
  - A response arriving when credits == MAX_OUTSTANDING is ignored; credits saturate, no wrap.
- credits == 0: no grants. A response at cycle t makes grants legal from t+1; the same-cycle response is not bypassed.
- grant_count_out increments by 1 per grant and wraps at 2^32.
- alfull asserted: grants stop in the same cycle. The output registered from the prior cycle's grant still issues; buffer headroom absorbs it.
- Reset mid-operation: all state returns to reset values immediately; any in-flight output valid is dropped.

Test Plan:
- Single requester 2 with both data valids, 3 entries back-to-back -> ready_out = 4'b0100 for 3 consecutive cycles; write_command_out.valid at t+1..t+3 carrying matching addresses; grant_count_out = 3.
- All 4 requesters continuously valid, 8 cycles -> grant order 0,1,2,3,0,1,2,3; pointer = 0 after the 8th grant.
- MAX_OUTSTANDING = 4, requester 0 always valid, no responses -> exactly 4 grants, then ready_out = 0 and outstanding_out = 4; one response -> exactly 1 further grant at the next cycle.
- Grant and response in the same cycle with credits = 1 -> credits stay 1, outstanding_out unchanged; response with credits = MAX -> credits stay MAX.
- write_command_buffer_status.alfull raised for 5 cycles while 2 requesters valid -> ready_out = 0 for those 5 cycles; after deassert, arbitration resumes from the held pointer.
- command_in[1].valid = 1 with write_data_1_in[1].valid = 0 -> requester 1 never granted; rstn pulsed mid-stream -> all outputs 0 and credits = MAX_OUTSTANDING while rstn low.

Source files
------------

// File: rtl/cu_write_command_arbiter_rr.sv
// rtl/cu_write_command_arbiter_rr.sv - round-robin write command/data arbiter with credit limiting
//
// Purpose: shares one write command buffer and its two half-cacheline write-data
// lanes among NUM_REQUESTERS write engines. One engine is granted per cycle,
// and its bundle is registered toward the buffers. A credit counter that is
// replenished by write responses caps the number of in-flight writes.
//
// Ports:
//   clock                        system clock
//   rstn                         asynchronous active-low reset
//   enabled_in                   block enable (registered before use)
//   command_in[N]                per-engine write command, .valid = request
//   write_data_0_in[N]           per-engine data lane 0
//   write_data_1_in[N]           per-engine data lane 1
//   ready_out[N]                 one-hot grant/pop strobe (combinational)
//   write_command_buffer_status  downstream command buffer status (alfull used)
//   write_response_in            write completion, returns one credit
//   write_command_out            registered granted command
//   write_data_0_out             registered granted lane 0
//   write_data_1_out             registered granted lane 1
//   outstanding_out              granted writes minus responses received
//   grant_count_out              total grants since reset (wraps)

package cu_write_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [7:0]  command;
        logic [63:0] address;
        logic [15:0] tag;
        logic [11:0] size;
    } CommandBufferLine;

    typedef struct packed {
        logic         valid;
        logic [15:0]  tag;
        logic [511:0] data;
    } ReadWriteDataLine;

    typedef struct packed {
        logic empty;
        logic alfull;
        logic full;
    } BufferStatus;

    typedef struct packed {
        logic        valid;
        logic [15:0] tag;
        logic [7:0]  response;
    } ResponseBufferLine;

endpackage

module cu_write_command_arbiter_rr
    import cu_write_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS  = 4,
    parameter int MAX_OUTSTANDING = 32,
    parameter int CREDIT_BITS     = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      enabled_in,
    input  CommandBufferLine          command_in      [NUM_REQUESTERS],
    input  ReadWriteDataLine          write_data_0_in [NUM_REQUESTERS],
    input  ReadWriteDataLine          write_data_1_in [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] ready_out,
    input  BufferStatus               write_command_buffer_status,
    input  ResponseBufferLine         write_response_in,
    output CommandBufferLine          write_command_out,
    output ReadWriteDataLine          write_data_0_out,
    output ReadWriteDataLine          write_data_1_out,
    output logic [CREDIT_BITS-1:0]    outstanding_out,
    output logic [31:0]               grant_count_out
);

    localparam int PTR_BITS = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(MAX_OUTSTANDING);
    localparam logic [PTR_BITS-1:0]    LAST_IDX   = PTR_BITS'(NUM_REQUESTERS - 1);

    logic                      r_enabled;
    logic [PTR_BITS-1:0]       r_ptr;
    logic [CREDIT_BITS-1:0]    r_credits;
    logic [CREDIT_BITS-1:0]    r_outstanding;
    logic [31:0]               r_grant_count;
    CommandBufferLine          r_command;
    ReadWriteDataLine          r_data_0;
    ReadWriteDataLine          r_data_1;

    logic [NUM_REQUESTERS-1:0] w_req;
    logic                      w_can_grant;
    logic                      w_grant;
    logic [PTR_BITS-1:0]       w_winner;
    logic [NUM_REQUESTERS-1:0] w_ready;
    logic [CREDIT_BITS-1:0]    w_credits_next;
    logic                      w_unused;

    // Only alfull and response.valid matter here; the rest is sunk.
    assign w_unused = ^{write_command_buffer_status, write_response_in};

    // An engine only requests when its command and both data halves are
    // present, so a granted bundle is always complete.
    generate
        for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_req
            assign w_req[g] = command_in[g].valid
                            & write_data_0_in[g].valid
                            & write_data_1_in[g].valid;
        end
    endgenerate

    // Credit exhaustion is checked against the registered count only; a
    // response arriving this cycle cannot enable a grant until next cycle.
    assign w_can_grant = r_enabled
                       & ~write_command_buffer_status.alfull
                       & (r_credits != '0);

    // Search from the pointer upward with wrap; first eligible engine wins.
    always_comb begin
        int                  v_idx;
        logic [PTR_BITS-1:0] v_sel;
        w_ready  = '0;
        w_grant  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        v_sel    = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQUESTERS) begin
                v_idx = v_idx - NUM_REQUESTERS;
            end
            v_sel = PTR_BITS'(v_idx);
            if (!w_grant && w_can_grant && w_req[v_sel]) begin
                w_grant  = 1'b1;
                w_winner = v_sel;
            end
        end
        if (w_grant) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    assign ready_out = w_ready;

    // Grant and response in the same cycle cancel. A response with all
    // credits already home is ignored so the counter saturates.
    always_comb begin
        w_credits_next = r_credits;
        if (w_grant && !write_response_in.valid) begin
            w_credits_next = r_credits - CREDIT_BITS'(1);
        end else if (!w_grant && write_response_in.valid && (r_credits != CREDIT_MAX)) begin
            w_credits_next = r_credits + CREDIT_BITS'(1);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_enabled     <= 1'b0;
            r_ptr         <= '0;
            r_credits     <= CREDIT_MAX;
            r_outstanding <= '0;
            r_grant_count <= '0;
            r_command     <= '0;
            r_data_0      <= '0;
            r_data_1      <= '0;
        end else begin
            r_enabled     <= enabled_in;
            r_credits     <= w_credits_next;
            r_outstanding <= CREDIT_MAX - w_credits_next;
            if (w_grant) begin
                r_ptr          <= (w_winner == LAST_IDX) ? '0 : w_winner + PTR_BITS'(1);
                r_grant_count  <= r_grant_count + 32'd1;
                r_command      <= command_in[w_winner];
                r_command.valid <= 1'b1;
                r_data_0       <= write_data_0_in[w_winner];
                r_data_0.valid <= 1'b1;
                r_data_1       <= write_data_1_in[w_winner];
                r_data_1.valid <= 1'b1;
            end else begin
                r_command <= '0;
                r_data_0  <= '0;
                r_data_1  <= '0;
            end
        end
    end

    assign write_command_out = r_command;
    assign write_data_0_out  = r_data_0;
    assign write_data_1_out  = r_data_1;
    assign outstanding_out   = r_outstanding;
    assign grant_count_out   = r_grant_count;

endmodule

// File: tb/tb_cu_write_command_arbiter_rr.sv
// tb/tb_cu_write_command_arbiter_rr.sv - scoreboard bench for cu_write_command_arbiter_rr
module tb_cu_write_command_arbiter_rr;
    import cu_write_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int MAX = 4;
    localparam int CB  = $clog2(MAX + 1);

    typedef struct packed {
        CommandBufferLine c;
        ReadWriteDataLine d0;
        ReadWriteDataLine d1;
    } bundle_t;

    logic              clock;
    logic              rstn;
    logic              enabled_in;
    CommandBufferLine  cmd_in [N];
    ReadWriteDataLine  d0_in  [N];
    ReadWriteDataLine  d1_in  [N];
    logic [N-1:0]      ready_out;
    BufferStatus       status;
    ResponseBufferLine resp;
    CommandBufferLine  cmd_out;
    ReadWriteDataLine  d0_out;
    ReadWriteDataLine  d1_out;
    logic [CB-1:0]     outstanding_out;
    logic [31:0]       grant_count_out;

    bundle_t sb_q[$];
    int      n_cmp;
    int      n_err;
    int      seq   [N];
    bit      c_on  [N];
    bit      d0_on [N];
    bit      d1_on [N];
    int      m_credits;
    int      m_gc;

    cu_write_command_arbiter_rr #(
        .NUM_REQUESTERS (N),
        .MAX_OUTSTANDING(MAX)
    ) dut (
        .clock                      (clock),
        .rstn                       (rstn),
        .enabled_in                 (enabled_in),
        .command_in                 (cmd_in),
        .write_data_0_in            (d0_in),
        .write_data_1_in            (d1_in),
        .ready_out                  (ready_out),
        .write_command_buffer_status(status),
        .write_response_in          (resp),
        .write_command_out          (cmd_out),
        .write_data_0_out           (d0_out),
        .write_data_1_out           (d1_out),
        .outstanding_out            (outstanding_out),
        .grant_count_out            (grant_count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            cmd_in[i].valid   = c_on[i];
            cmd_in[i].command = 8'h20;
            cmd_in[i].address = (64'(i) << 32) | (64'(seq[i]) << 7);
            cmd_in[i].tag     = 16'(i * 256 + seq[i]);
            cmd_in[i].size    = 12'd128;
            d0_in[i].valid    = d0_on[i];
            d0_in[i].tag      = 16'(i * 256 + seq[i]);
            d0_in[i].data     = {16{32'((i << 16) | seq[i])}};
            d1_in[i].valid    = d1_on[i];
            d1_in[i].tag      = 16'(i * 256 + seq[i]);
            d1_in[i].data     = ~{16{32'((i << 16) | seq[i])}};
        end
    endtask

    task automatic set_req(input int i, input bit c, input bit a, input bit b);
        c_on[i]  = c;
        d0_on[i] = a;
        d1_on[i] = b;
    endtask

    // One arbitration cycle: inputs already driven after a negedge.
    task automatic tick(input logic [N-1:0] exp_ready, input string tag);
        bundle_t b;
        int      w;
        w = 0;
        #1;
        chk({tag, " ready"}, 640'(ready_out), 640'(exp_ready));
        if (exp_ready != '0) begin
            for (int i = 0; i < N; i++) if (exp_ready[i]) w = i;
            b.c        = cmd_in[w];
            b.c.valid  = 1'b1;
            b.d0       = d0_in[w];
            b.d0.valid = 1'b1;
            b.d1       = d1_in[w];
            b.d1.valid = 1'b1;
            m_gc++;
            if (!resp.valid) m_credits--;
            seq[w]++;
        end else begin
            b = '0;
            if (resp.valid && m_credits < MAX) m_credits++;
        end
        sb_q.push_back(b);
        @(posedge clock);
        #1;
        b = sb_q.pop_front();
        chk({tag, " cmd"},  640'(cmd_out), 640'(b.c));
        chk({tag, " d0"},   640'(d0_out),  640'(b.d0));
        chk({tag, " d1"},   640'(d1_out),  640'(b.d1));
        chk({tag, " gcnt"}, 640'(grant_count_out), 640'(m_gc));
        chk({tag, " outst"}, 640'(outstanding_out), 640'(MAX - m_credits));
        @(negedge clock);
        drive();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ready"}, 640'(ready_out), 640'(0));
        chk({tag, " cmd"},   640'(cmd_out), 640'(0));
        chk({tag, " d0"},    640'(d0_out), 640'(0));
        chk({tag, " d1"},    640'(d1_out), 640'(0));
        chk({tag, " outst"}, 640'(outstanding_out), 640'(0));
        chk({tag, " gcnt"},  640'(grant_count_out), 640'(0));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_credits = MAX;
        m_gc = 0;
        rstn = 1'b1;
        enabled_in = 1'b0;
        status = '0;
        resp = '0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            set_req(i, 0, 0, 0);
        end
        drive();
        #2 rstn = 1'b0;
        repeat (2) @(negedge clock);
        chk_reset("reset");

        rstn = 1'b1;
        enabled_in = 1'b1;
        tick(4'b0000, "enable lag");

        // Round robin with all requesters; response each cycle keeps credits full.
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 1);
        resp.valid = 1'b1;
        resp.tag = 16'h55;
        drive();
        for (int k = 0; k < 8; k++) tick(4'(1 << (k % N)), "rr");
        tick(4'b0001, "rr ptr0");
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0);
        resp.valid = 1'b0;
        drive();
        tick(4'b0000, "rr idle");

        // Single requester 2, three entries back to back.
        set_req(2, 1, 1, 1);
        drive();
        for (int k = 0; k < 3; k++) tick(4'b0100, "single2");
        // Grant and response together at credits = 1.
        resp.valid = 1'b1;
        drive();
        tick(4'b0100, "grant+resp");
        set_req(2, 0, 0, 0);
        resp.valid = 1'b0;

        // Credit exhaustion on requester 0.
        set_req(0, 1, 1, 1);
        drive();
        tick(4'b0001, "last credit");
        tick(4'b0000, "no credit a");
        tick(4'b0000, "no credit b");
        resp.valid = 1'b1;
        drive();
        tick(4'b0000, "resp no bypass");
        resp.valid = 1'b0;
        drive();
        tick(4'b0001, "credit regrant");
        tick(4'b0000, "no credit c");
        set_req(0, 0, 0, 0);
        resp.valid = 1'b1;
        drive();
        for (int k = 0; k < MAX; k++) tick(4'b0000, "drain");
        tick(4'b0000, "resp at max");
        resp.valid = 1'b0;

        // alfull with requesters 0 and 3; pointer is 1 here.
        set_req(0, 1, 1, 1);
        set_req(3, 1, 1, 1);
        drive();
        tick(4'b1000, "pre alfull");
        status.alfull = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) tick(4'b0000, "alfull");
        status.alfull = 1'b0;
        drive();
        tick(4'b0001, "resume a");
        tick(4'b1000, "resume b");
        set_req(0, 0, 0, 0);
        set_req(3, 0, 0, 0);

        // Incomplete bundles on requester 1 are never granted (credit 1 left).
        set_req(1, 1, 1, 0);
        drive();
        for (int k = 0; k < 3; k++) tick(4'b0000, "no d1");
        set_req(1, 1, 0, 1);
        drive();
        tick(4'b0000, "no d0");
        set_req(1, 0, 0, 0);
        resp.valid = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) tick(4'b0000, "drain2");
        resp.valid = 1'b0;

        // Reset while an output bundle is valid.
        set_req(0, 1, 1, 1);
        set_req(2, 1, 1, 1);
        drive();
        tick(4'b0001, "pre reset");
        rstn = 1'b0;
        #1;
        chk_reset("mid reset");
        @(posedge clock);
        #1;
        chk_reset("reset held");
        sb_q.delete();
        m_credits = MAX;
        m_gc = 0;
        @(negedge clock);
        rstn = 1'b1;
        tick(4'b0000, "post reset lag");
        tick(4'b0001, "post reset ptr0");
        tick(4'b0100, "post reset rr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
